// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and helpers for the instruction fetch aligner
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        ISSUE,
        DRAIN
    } fetch_state_t;

    // A 16-bit parcel is compressed unless its two low bits are both set.
    function automatic logic is_compressed(input logic [15:0] half);
        return (half & 16'h0003) != 16'h0003;
    endfunction

    // Word-aligned address containing the given PC; callers truncate to XLEN.
    function automatic logic [63:0] word_addr(input logic [63:0] pc);
        return pc & ~64'h3;
    endfunction

endpackage

// File: rtl/fetch_aligner.sv
// rtl/fetch_aligner.sv - instruction fetch sequencer with compressed split and straddle stitching
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   imem_req/addr/gnt     word fetch request (held until granted), word-aligned address
//   imem_rvalid/rdata     response word, at most one outstanding request
//   instr_out/pc/comp     presented instruction (compressed zero-extended), its PC, compressed flag
//   instr_valid/ready     instruction handshake
//   redirect_valid/pc     load a new PC (bit 0 ignored), highest priority
module fetch_aligner
    import fetch_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr_out,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_comp,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam logic [XLEN-1:0] PC_RST = RESET_PC & ~XLEN'(1);

    function automatic logic [XLEN-1:0] wa(input logic [XLEN-1:0] a);
        return XLEN'(word_addr(64'(a)));
    endfunction

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     buf_word_q, buf_word_d;
    logic [XLEN-1:0] buf_addr_q, buf_addr_d;
    logic            buf_valid_q, buf_valid_d;
    logic [15:0]     spill_q, spill_d;
    logic            spill_valid_q, spill_valid_d;

    logic            req_d, comp_d, valid_d;
    logic [XLEN-1:0] addr_d, opc_d;
    logic [31:0]     out_d;

    logic [XLEN-1:0] redir_pc, adv_pc;
    logic [15:0]     half;
    logic            pres;
    logic [31:0]     pres_word;

    assign redir_pc = redirect_pc & ~XLEN'(1);
    assign adv_pc   = pc_q + (instr_comp ? XLEN'(2) : XLEN'(4));

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        buf_word_d    = buf_word_q;
        buf_addr_d    = buf_addr_q;
        buf_valid_d   = buf_valid_q;
        spill_d       = spill_q;
        spill_valid_d = spill_valid_q;
        req_d         = imem_req;
        addr_d        = imem_addr;
        out_d         = instr_out;
        opc_d         = instr_pc;
        comp_d        = instr_comp;
        valid_d       = instr_valid;
        half          = '0;
        pres          = 1'b0;
        pres_word     = '0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
                req_d   = 1'b1;
                addr_d  = wa(pc_q);
            end
            FETCH: begin
                if (redirect_valid) begin
                    pc_d          = redir_pc;
                    buf_valid_d   = 1'b0;
                    spill_valid_d = 1'b0;
                    if (imem_gnt) begin
                        // The old request is already in flight; its response must be dropped.
                        state_d = DRAIN;
                        req_d   = 1'b0;
                    end else begin
                        addr_d = wa(redir_pc);
                    end
                end else if (imem_gnt) begin
                    state_d = WAIT;
                    req_d   = 1'b0;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d          = redir_pc;
                    buf_valid_d   = 1'b0;
                    spill_valid_d = 1'b0;
                    if (imem_rvalid) begin
                        state_d = FETCH;
                        req_d   = 1'b1;
                        addr_d  = wa(redir_pc);
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (imem_rvalid) begin
                    buf_word_d    = imem_rdata;
                    buf_addr_d    = imem_addr;
                    buf_valid_d   = 1'b1;
                    spill_valid_d = 1'b0;
                    if (spill_valid_q) begin
                        pres      = 1'b1;
                        pres_word = {imem_rdata[15:0], spill_q};
                    end else if (!pc_q[1]) begin
                        pres      = 1'b1;
                        pres_word = is_compressed(imem_rdata[15:0]) ? {16'b0, imem_rdata[15:0]}
                                                                    : imem_rdata;
                    end else if (is_compressed(imem_rdata[31:16])) begin
                        pres      = 1'b1;
                        pres_word = {16'b0, imem_rdata[31:16]};
                    end else begin
                        // Entered mid-word on the low half of a 32-bit instruction.
                        spill_d       = imem_rdata[31:16];
                        spill_valid_d = 1'b1;
                        state_d       = FETCH;
                        req_d         = 1'b1;
                        addr_d        = imem_addr + XLEN'(4);
                    end
                end
            end
            ISSUE: begin
                if (redirect_valid) begin
                    pc_d          = redir_pc;
                    buf_valid_d   = 1'b0;
                    spill_valid_d = 1'b0;
                    valid_d       = 1'b0;
                    state_d       = FETCH;
                    req_d         = 1'b1;
                    addr_d        = wa(redir_pc);
                end else if (instr_ready) begin
                    pc_d    = adv_pc;
                    valid_d = 1'b0;
                    if (buf_valid_q && wa(adv_pc) == buf_addr_q) begin
                        half = adv_pc[1] ? buf_word_q[31:16] : buf_word_q[15:0];
                        if (is_compressed(half)) begin
                            pres      = 1'b1;
                            pres_word = {16'b0, half};
                        end else if (!adv_pc[1]) begin
                            pres      = 1'b1;
                            pres_word = buf_word_q;
                        end else begin
                            spill_d       = half;
                            spill_valid_d = 1'b1;
                            state_d       = FETCH;
                            req_d         = 1'b1;
                            addr_d        = buf_addr_q + XLEN'(4);
                        end
                    end else begin
                        state_d = FETCH;
                        req_d   = 1'b1;
                        addr_d  = wa(adv_pc);
                    end
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    pc_d          = redir_pc;
                    buf_valid_d   = 1'b0;
                    spill_valid_d = 1'b0;
                end
                if (imem_rvalid) begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                    addr_d  = wa(pc_d);
                end
            end
            default: state_d = IDLE;
        endcase

        // pc_d already holds the PC of the instruction being presented.
        if (pres) begin
            state_d = ISSUE;
            out_d   = pres_word;
            opc_d   = pc_d;
            comp_d  = is_compressed(pres_word[15:0]);
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= PC_RST;
            buf_word_q    <= '0;
            buf_addr_q    <= '0;
            buf_valid_q   <= 1'b0;
            spill_q       <= '0;
            spill_valid_q <= 1'b0;
            imem_req      <= 1'b0;
            imem_addr     <= '0;
            instr_out     <= '0;
            instr_pc      <= '0;
            instr_comp    <= 1'b0;
            instr_valid   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            buf_word_q    <= buf_word_d;
            buf_addr_q    <= buf_addr_d;
            buf_valid_q   <= buf_valid_d;
            spill_q       <= spill_d;
            spill_valid_q <= spill_valid_d;
            imem_req      <= req_d;
            imem_addr     <= addr_d;
            instr_out     <= out_d;
            instr_pc      <= opc_d;
            instr_comp    <= comp_d;
            instr_valid   <= valid_d;
        end
    end

endmodule

// File: doc/fetch_aligner.md
Name: fetch_aligner

Overview:
- Instruction fetch sequencer between instruction memory and control_unit.
- Fetches 32-bit aligned words and presents one instruction at a time, 16-bit (compressed) or 32-bit, with its PC.
- Splits packed compressed pairs and stitches 32-bit instructions that straddle a word boundary.
- Handles PC redirects from branch/jump resolution, including discarding a stale in-flight response.

Parameters:
XLEN, 32, address/PC width
RESET_PC, 0, first PC after reset; bit 0 forced to 0

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
imem_req  out  1  word fetch request; held until granted
imem_addr  out  XLEN  fetch address, bits[1:0]=0
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response word valid; at most one outstanding request, earliest response the cycle after grant
imem_rdata  in  32  response word
instr_out  out  32  instruction; compressed returned as {16'b0, half}
instr_pc  out  XLEN  PC of instr_out
instr_comp  out  1  instr_out[1:0] != 2'b11
instr_valid  out  1  instruction presented
instr_ready  in  1  consumer accepts instruction
redirect_valid  in  1  load new PC
redirect_pc  in  XLEN  target PC; bit 0 ignored

Behaviour:
- One clock, clk; reset synchronous, active-low on rst_n.
- State: pc; buf_word/buf_addr/buf_valid (last fetched word); spill (16 bits); FSM IDLE, FETCH, WAIT, ISSUE, DRAIN.
- Reset (rst_n=0 at a clk edge):
  - State -> IDLE; pc=RESET_PC; buf_valid=0.
  - Outputs: imem_req=0, imem_addr=0, instr_out=0, instr_pc=0, instr_comp=0, instr_valid=0.
- IDLE -> FETCH on the first cycle after reset release.
- FETCH:
  - imem_req=1, imem_addr = target word.
  - On imem_gnt -> WAIT.
  - The address may change only via redirect while ungranted.
- WAIT:
  - On imem_rvalid, latch the word into buf.
  - If pc[1]=1 and the instruction spills over, combine {rdata[15:0], spill}.
  - Then -> ISSUE.
- ISSUE:
  - instr_valid=1; instr_out, instr_pc and instr_comp are registered and stable while ready=0.
  - Transfer occurs when valid & ready; pc += 2 (compressed) or 4.
- Next-state after a transfer:
  - New instruction wholly inside buf (compressed upper half, or full word at pc[1]=0 already in buf): stay ISSUE, present it next cycle, no fetch.
  - New pc[1]=1, upper half is the low half of a 32-bit instruction: spill <= upper half; FETCH word buf_addr+4.
  - Otherwise: FETCH word pc & ~3.
- Latency:
  - Reset release at edge N: req at N+1; if gnt at N+1 and rvalid at N+2, instr_valid at N+3.
  - Back-to-back compressed instructions from one buffered word issue on consecutive cycles.
- Redirect (any non-IDLE state, highest priority):
  - pc <= {redirect_pc[XLEN-1:1],0}; buf_valid=0; spill discarded; instr_valid=0 next cycle.
  - In FETCH without gnt: retarget and stay FETCH.
  - In FETCH with gnt the same cycle, or in WAIT without rvalid: -> DRAIN.
  - In WAIT with rvalid the same cycle: drop the word, -> FETCH.
  - In ISSUE: a same-cycle ready does not advance pc.
- DRAIN: wait for imem_rvalid, discard the data, -> FETCH. A redirect while in DRAIN updates pc only.
- pc arithmetic wraps modulo 2^XLEN; buf_addr+4 wraps likewise.
- imem_rvalid outside WAIT/DRAIN is ignored.

Decomposition:
- fetch_pkg:
  - fetch_state_t enum (IDLE, FETCH, WAIT, ISSUE, DRAIN).
  - Function is_compressed(half) = half[1:0] != 2'b11.
  - Function word_addr(pc).
- No sub-module; the datapath is a single always_ff/always_comb pair.

Test Plan:
- Straight 32-bit: mem[0]=0x00000013, mem[4]=0x00100093, ready=1, gnt same cycle, rvalid next cycle -> (0x00000013, pc 0), then (0x00100093, pc 4); instr_comp=0.
- Compressed pair: mem[0]=0x45010001 -> (0x00000001, pc 0) then (0x00004501, pc 2) on consecutive cycles; exactly one imem_req for address 0.
- Straddle:
  - Stimulus: mem[0]=0x00930001, mem[4]=0x12340010.
  - Issue order: (0x00000001, pc 0), then (0x00100093, pc 2), then (0x00001234, pc 6).
  - Fetches: only 0x0 and 0x4, never refetching 0x4.
- Redirect in WAIT: redirect_pc=0x101 while awaiting response:
  - Stale rvalid data is never issued.
  - Next imem_addr=0x100; first issue has instr_pc=0x100.
- Backpressure: ready=0 for 5 cycles at pc 4 -> instr_out/instr_pc constant, instr_valid=1, imem_req=0; the transfer on ready=1 advances normally.
- Reset mid-spill: assert rst_n=0 in FETCH awaiting the second straddle word:
  - All outputs 0 the next cycle.
  - After release, first req address = RESET_PC and no spilled data appears.
